// File: rtl/load_store_unit.sv
// Data-memory initiator for RV32I loads and stores: byte/half/word access with
// sign/zero extension and read-modify-write for sub-word stores (big-endian lanes).
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_store_data,
    output logic              resp_valid,
    output logic [31:0]       resp_load_data,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    state_t      state;
    logic [1:0]  offset_q;
    logic [2:0]  funct3_q;
    logic [15:0] store_data_q;

    logic        funct3_legal;
    logic        misaligned;
    logic [4:0]  byte_shift;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_read   = (state == RD) || (state == RMW_RD);
    // Gating with reset keeps a write from escaping in the cycle reset is raised.
    assign mem_write  = (state == WR) && !reset;

    always_comb begin
        funct3_legal = 1'b0;
        if (req_is_store)
            funct3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            funct3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Offset 0 is the most significant byte, so the lane shift is (3 - offset) * 8.
    always_comb begin
        byte_shift = {~offset_q, 3'b000};
        lane_byte  = 8'(mem_read_data >> byte_shift);
        lane_half  = offset_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'd0, lane_byte};
            3'b101:  load_ext = {16'd0, lane_half};
            default: load_ext = mem_read_data;
        endcase
        if (!funct3_q[0])
            merged = (mem_read_data & ~(32'h0000_00FF << byte_shift)) |
                     ({24'd0, store_data_q[7:0]} << byte_shift);
        else if (offset_q[1])
            merged = {mem_read_data[31:16], store_data_q};
        else
            merged = {store_data_q, mem_read_data[15:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            offset_q       <= 2'b00;
            funct3_q       <= 3'b000;
            store_data_q   <= 16'd0;
            resp_load_data <= 32'd0;
            resp_err       <= 1'b0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        offset_q       <= req_addr[1:0];
                        funct3_q       <= req_funct3;
                        store_data_q   <= req_store_data[15:0];
                        mem_address    <= 32'(req_addr) & 32'hFFFF_FFFC;
                        resp_load_data <= 32'd0;
                        resp_err       <= 1'b0;
                        if (!funct3_legal || misaligned) begin
                            resp_err <= 1'b1;
                            state    <= RESP;
                        end else if (!req_is_store) begin
                            state <= RD;
                        end else if (req_funct3 == 3'b010) begin
                            mem_write_data <= req_store_data;
                            state          <= WR;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    resp_load_data <= load_ext;
                    state          <= RESP;
                end
                RMW_RD: begin
                    mem_write_data <= merged;
                    state          <= WR;
                end
                WR:      state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word-organised memory.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_store_data;
    logic        resp_valid;
    logic [31:0] resp_load_data;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    int          write_pulses;

    int compared;
    int mismatched;

    int          obs_lat, obs_rd_at, obs_wr_at, obs_nrd, obs_nwr;
    logic [31:0] obs_addr, obs_wdata, obs_data;
    logic        obs_err;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_store_data(req_store_data),
        .resp_valid(resp_valid), .resp_load_data(resp_load_data), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words beyond the modelled 1 KiB read back as 0xDEADBEEF.
    assign mem_read_data = (mem_address[31:2] < 30'd256) ? mem[mem_address[9:2]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (mem_write) begin
            write_pulses <= write_pulses + 1;
            if (mem_address[31:2] < 30'd256)
                mem[mem_address[9:2]] <= mem_write_data;
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data);
        obs_lat = -1; obs_rd_at = -1; obs_wr_at = -1; obs_nrd = 0; obs_nwr = 0;
        obs_addr = 32'hFFFF_FFFF; obs_wdata = 32'hFFFF_FFFF; obs_data = 32'hFFFF_FFFF; obs_err = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_store_data = data;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (mem_read) begin
                obs_nrd++; obs_addr = mem_address;
                if (obs_rd_at < 0) obs_rd_at = k;
            end
            if (mem_write) begin
                obs_nwr++; obs_wdata = mem_write_data; obs_addr = mem_address;
                if (obs_wr_at < 0) obs_wr_at = k;
            end
            if (resp_valid) begin
                obs_lat = k; obs_data = resp_load_data; obs_err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_store_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        compared++; if (resp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_resp_err: got %b expected 0", resp_err); end
        compared++; if (resp_load_data !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_load_data: got %h expected 00000000", resp_load_data); end
        compared++; if ({mem_read, mem_write} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_mem_strobes: got %b expected 00", {mem_read, mem_write}); end
        compared++; if (mem_address !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_mem_address: got %h expected 00000000", mem_address); end
        compared++; if (mem_write_data !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_mem_write_data: got %h expected 00000000", mem_write_data); end
        reset = 1'b0;
    endtask

    task automatic test_load_basic();
        mem[4] = 32'h1122_3344;
        do_req(1'b0, 3'b000, 32'h13, 32'd0);
        compared++; if (obs_lat !== 2) begin mismatched++; $display("[TB] FAIL lb_latency: got %0d expected 2", obs_lat); end
        compared++; if (obs_data !== 32'h0000_0044) begin mismatched++; $display("[TB] FAIL lb_data: got %h expected 00000044", obs_data); end
        compared++; if (obs_nrd !== 1) begin mismatched++; $display("[TB] FAIL lb_read_cycles: got %0d expected 1", obs_nrd); end
        compared++; if (obs_addr !== 32'h10) begin mismatched++; $display("[TB] FAIL lb_address: got %h expected 00000010", obs_addr); end
        compared++; if (obs_err !== 1'b0) begin mismatched++; $display("[TB] FAIL lb_err: got %b expected 0", obs_err); end
        @(negedge clk);
        compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL lb_resp_one_cycle: got %b expected 0", resp_valid); end
        compared++; if (mem_address !== 32'h10) begin mismatched++; $display("[TB] FAIL lb_address_held: got %h expected 00000010", mem_address); end
        do_req(1'b0, 3'b010, 32'h10, 32'd0);
        compared++; if (obs_data !== 32'h1122_3344) begin mismatched++; $display("[TB] FAIL lw_data: got %h expected 11223344", obs_data); end
    endtask

    task automatic test_extension();
        mem[8] = 32'h80FF_7F01;
        do_req(1'b0, 3'b000, 32'h20, 32'd0);
        compared++; if (obs_data !== 32'hFFFF_FF80) begin mismatched++; $display("[TB] FAIL lb_sign: got %h expected ffffff80", obs_data); end
        do_req(1'b0, 3'b100, 32'h20, 32'd0);
        compared++; if (obs_data !== 32'h0000_0080) begin mismatched++; $display("[TB] FAIL lbu_zero: got %h expected 00000080", obs_data); end
        do_req(1'b0, 3'b001, 32'h20, 32'd0);
        compared++; if (obs_data !== 32'hFFFF_80FF) begin mismatched++; $display("[TB] FAIL lh_sign: got %h expected ffff80ff", obs_data); end
        do_req(1'b0, 3'b101, 32'h22, 32'd0);
        compared++; if (obs_data !== 32'h0000_7F01) begin mismatched++; $display("[TB] FAIL lhu_zero: got %h expected 00007f01", obs_data); end
        do_req(1'b0, 3'b000, 32'h22, 32'd0);
        compared++; if (obs_data !== 32'h0000_007F) begin mismatched++; $display("[TB] FAIL lb_off2: got %h expected 0000007f", obs_data); end
    endtask

    task automatic test_sub_word_store();
        mem[4] = 32'h1122_3344;
        do_req(1'b1, 3'b000, 32'h11, 32'h1234_56AB);
        compared++; if (obs_rd_at !== 1) begin mismatched++; $display("[TB] FAIL sb_read_cycle: got %0d expected 1", obs_rd_at); end
        compared++; if (obs_wr_at !== 2) begin mismatched++; $display("[TB] FAIL sb_write_cycle: got %0d expected 2", obs_wr_at); end
        compared++; if (obs_nwr !== 1) begin mismatched++; $display("[TB] FAIL sb_write_count: got %0d expected 1", obs_nwr); end
        compared++; if (obs_wdata !== 32'h11AB_3344) begin mismatched++; $display("[TB] FAIL sb_merge: got %h expected 11ab3344", obs_wdata); end
        compared++; if (obs_lat !== 3) begin mismatched++; $display("[TB] FAIL sb_latency: got %0d expected 3", obs_lat); end
        compared++; if (obs_data !== 32'd0) begin mismatched++; $display("[TB] FAIL sb_load_data: got %h expected 00000000", obs_data); end
        do_req(1'b0, 3'b010, 32'h10, 32'd0);
        compared++; if (obs_data !== 32'h11AB_3344) begin mismatched++; $display("[TB] FAIL sb_readback: got %h expected 11ab3344", obs_data); end
        mem[4] = 32'h1122_3344;
        do_req(1'b1, 3'b001, 32'h12, 32'h0000_BEEF);
        compared++; if (obs_wdata !== 32'h1122_BEEF) begin mismatched++; $display("[TB] FAIL sh_merge: got %h expected 1122beef", obs_wdata); end
        compared++; if (obs_lat !== 3) begin mismatched++; $display("[TB] FAIL sh_latency: got %0d expected 3", obs_lat); end
        do_req(1'b1, 3'b001, 32'h10, 32'h0000_5566);
        compared++; if (obs_wdata !== 32'h5566_BEEF) begin mismatched++; $display("[TB] FAIL sh_upper_merge: got %h expected 5566beef", obs_wdata); end
    endtask

    task automatic test_store_word();
        do_req(1'b1, 3'b010, 32'h14, 32'hCAFE_F00D);
        compared++; if (obs_wr_at !== 1) begin mismatched++; $display("[TB] FAIL sw_write_cycle: got %0d expected 1", obs_wr_at); end
        compared++; if (obs_nrd !== 0 || obs_nwr !== 1) begin mismatched++; $display("[TB] FAIL sw_strobes: got rd=%0d wr=%0d expected rd=0 wr=1", obs_nrd, obs_nwr); end
        compared++; if (obs_lat !== 2) begin mismatched++; $display("[TB] FAIL sw_latency: got %0d expected 2", obs_lat); end
        compared++; if (obs_addr !== 32'h14 || obs_wdata !== 32'hCAFE_F00D) begin mismatched++; $display("[TB] FAIL sw_write: got %h@%h expected cafef00d@00000014", obs_wdata, obs_addr); end
    endtask

    task automatic test_errors();
        do_req(1'b0, 3'b010, 32'h12, 32'd0);
        compared++; if (obs_lat !== 1 || obs_err !== 1'b1) begin mismatched++; $display("[TB] FAIL lw_misaligned: got lat=%0d err=%b expected lat=1 err=1", obs_lat, obs_err); end
        compared++; if (obs_nrd !== 0 || obs_nwr !== 0 || obs_data !== 32'd0) begin mismatched++; $display("[TB] FAIL lw_misaligned_side: got rd=%0d wr=%0d data=%h expected 0 0 00000000", obs_nrd, obs_nwr, obs_data); end
        do_req(1'b0, 3'b001, 32'h11, 32'd0);
        compared++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_nrd !== 0) begin mismatched++; $display("[TB] FAIL lh_misaligned: got lat=%0d err=%b rd=%0d expected 1 1 0", obs_lat, obs_err, obs_nrd); end
        do_req(1'b0, 3'b011, 32'h10, 32'd0);
        compared++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_data !== 32'd0) begin mismatched++; $display("[TB] FAIL load_funct3_011: got lat=%0d err=%b data=%h expected 1 1 00000000", obs_lat, obs_err, obs_data); end
        do_req(1'b1, 3'b100, 32'h10, 32'h1);
        compared++; if (obs_err !== 1'b1 || obs_nwr !== 0) begin mismatched++; $display("[TB] FAIL store_funct3_100: got err=%b wr=%0d expected 1 0", obs_err, obs_nwr); end
        do_req(1'b0, 3'b010, 32'h10, 32'd0);
        compared++; if (obs_err !== 1'b0) begin mismatched++; $display("[TB] FAIL err_cleared: got %b expected 0", obs_err); end
    endtask

    task automatic test_reset_during_rmw();
        int pulses_before;
        mem[4] = 32'h1122_3344;
        pulses_before = write_pulses;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_store_data = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_rmw_ready: got %b expected 1", req_ready); end
        repeat (3) @(negedge clk);
        compared++; if (write_pulses !== pulses_before) begin mismatched++; $display("[TB] FAIL rst_rmw_no_write: got %0d expected %0d", write_pulses, pulses_before); end
        compared++; if (mem[4] !== 32'h1122_3344) begin mismatched++; $display("[TB] FAIL rst_rmw_word: got %h expected 11223344", mem[4]); end
    endtask

    task automatic test_out_of_bounds();
        do_req(1'b0, 3'b010, 32'h1000, 32'd0);
        compared++; if (obs_data !== 32'hDEAD_BEEF || obs_err !== 1'b0) begin mismatched++; $display("[TB] FAIL oob_load: got %h err=%b expected deadbeef err=0", obs_data, obs_err); end
        compared++; if (obs_addr !== 32'h1000) begin mismatched++; $display("[TB] FAIL oob_address: got %h expected 00001000", obs_addr); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        write_pulses = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        test_reset();
        test_load_basic();
        test_extension();
        test_sub_word_store();
        test_store_word();
        test_errors();
        test_reset_during_rmw();
        test_out_of_bounds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
